// File: rtl/matmul_apb_master.sv
// matmul_apb_master: command/response stream to APB initiator with busy polling and pready timeout
module matmul_apb_master #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MAX_DIM        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    input  logic                  cmd_wait_busy_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  busy_i
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [2:0] {IDLE, WAIT_BUSY, SETUP, ACCESS, RESP} state_t;
    state_t                state;
    logic                  c_write;
    logic                  c_wait;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [BUS_WIDTH-1:0]  c_wdata;
    logic [MAX_DIM-1:0]    c_strb;
    logic [CW-1:0]         cnt;
    logic [BUS_WIDTH-1:0]  r_rdata;
    logic                  r_err;
    logic                  r_to;
    logic                  tmo;
    logic                  xfer;
    logic                  wr;
    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == LAST);
    assign xfer = (state == SETUP) || (state == ACCESS);
    assign wr = xfer && c_write;
    assign cmd_ready_o = state == IDLE;
    assign psel_o = xfer;
    assign penable_o = state == ACCESS;
    assign pwrite_o = wr;
    assign paddr_o = xfer ? c_addr : '0;
    assign pwdata_o = wr ? c_wdata : '0;
    assign pstrb_o = wr ? c_strb : '0;
    assign rsp_valid_o = state == RESP;
    assign rsp_rdata_o = rsp_valid_o ? r_rdata : '0;
    assign rsp_err_o = rsp_valid_o && r_err;
    assign rsp_timeout_o = rsp_valid_o && r_to;
    // Transfer sequencer: command capture, busy polling, APB phases, response hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            c_write <= 1'b0;
            c_wait  <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            c_strb  <= '0;
            cnt     <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i) begin
                    c_write <= cmd_write_i;
                    c_wait  <= cmd_wait_busy_i;
                    c_addr  <= cmd_addr_i;
                    c_wdata <= cmd_wdata_i;
                    c_strb  <= cmd_strb_i;
                    cnt     <= '0;
                    state   <= (cmd_wait_busy_i && busy_i) ? WAIT_BUSY : SETUP;
                end
                WAIT_BUSY: if (!c_wait || !busy_i) begin
                    state <= SETUP;
                end else if (tmo) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_to    <= 1'b1;
                    state   <= RESP;
                end else begin
                    cnt <= (&cnt) ? cnt : cnt + CW'(1);
                end
                SETUP: begin
                    cnt   <= '0;
                    state <= ACCESS;
                end
                ACCESS: if (pready_i) begin
                    r_rdata <= c_write ? '0 : prdata_i;
                    r_err   <= pslverr_i;
                    r_to    <= 1'b0;
                    state   <= RESP;
                end else if (tmo) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_to    <= 1'b1;
                    state   <= RESP;
                end else begin
                    cnt <= (&cnt) ? cnt : cnt + CW'(1);
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_apb_master.sv
// tb_matmul_apb_master: scenario tasks with a response scoreboard for matmul_apb_master
module tb_matmul_apb_master;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [15:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_strb_i = '0;
    logic        cmd_wait_busy_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic [31:0] prdata_i = '0;
    logic        busy_i = 1'b0;
    int total = 0;
    int bad = 0;
    rsp_t sb[$];
    rsp_t e;
    matmul_apb_master #(
        .BUS_WIDTH(32), .ADDR_WIDTH(16), .MAX_DIM(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .cmd_wait_busy_i(cmd_wait_busy_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i), .busy_i(busy_i)
    );
    always #5 clk_i = ~clk_i;
    // Present one command at a negedge, accept at edge N, return at the negedge of cycle N+1
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic wb);
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d;
        cmd_strb_i = s; cmd_wait_busy_i = wb;
        total++;
        if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", cmd_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({cmd_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o} !== 5'b10000)
            begin bad++; $display("FAIL reset_ctrl got=%b want=10000", {cmd_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o}); end
        total++;
        if ({paddr_o, pwdata_o, pstrb_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== '0)
            begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", paddr_o, pwdata_o, pstrb_o, rsp_rdata_o); end
    endtask
    task automatic test_write();
        pready_i = 1'b1; rsp_ready_i = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b0);
        total++;
        if ({psel_o, penable_o, pwrite_o} !== 3'b101)
            begin bad++; $display("FAIL wr_setup got=%b want=101", {psel_o, penable_o, pwrite_o}); end
        total++;
        if ({paddr_o, pwdata_o, pstrb_o} !== {16'h0004, 32'hDEADBEEF, 4'hF})
            begin bad++; $display("FAIL wr_bus got=%h %h %h want=0004 deadbeef f", paddr_o, pwdata_o, pstrb_o); end
        @(negedge clk_i);
        total++;
        if ({psel_o, penable_o, rsp_valid_o} !== 3'b110)
            begin bad++; $display("FAIL wr_access got=%b want=110", {psel_o, penable_o, rsp_valid_o}); end
        @(negedge clk_i);
        pready_i = 1'b0;
        total++;
        if ({rsp_valid_o, psel_o, penable_o} !== 3'b100)
            begin bad++; $display("FAIL wr_rsp_valid got=%b want=100", {rsp_valid_o, psel_o, penable_o}); end
        e = sb.pop_front();
        total++;
        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e)
            begin bad++; $display("FAIL wr_rsp got=%h %b %b want=%h %b %b", rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        @(negedge clk_i);
        total++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01)
            begin bad++; $display("FAIL wr_done got=%b want=01", {rsp_valid_o, cmd_ready_o}); end
    endtask
    task automatic test_read_wait();
        int pen = 0;
        pready_i = 1'b0;
        sb.push_back('{rdata: 32'h12345678, err: 1'b0, to: 1'b0});
        issue(1'b0, 16'h0010, 32'hFFFFFFFF, 4'hF, 1'b0);
        total++;
        if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o} !== {3'b100, 16'h0010, 32'h0, 4'h0})
            begin bad++; $display("FAIL rd_setup got=%b %h %h %h want=100 0010 0 0", {psel_o, penable_o, pwrite_o}, paddr_o, pwdata_o, pstrb_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (penable_o === 1'b1 && psel_o === 1'b1 && rsp_valid_o === 1'b0) pen++;
            if (i == 3) begin pready_i = 1'b1; prdata_i = 32'h12345678; end
        end
        total++;
        if (pen != 4) begin bad++; $display("FAIL rd_penable_cycles got=%0d want=4", pen); end
        @(negedge clk_i);
        pready_i = 1'b0; prdata_i = '0;
        total++;
        if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%b want=1", rsp_valid_o); end
        e = sb.pop_front();
        total++;
        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e)
            begin bad++; $display("FAIL rd_rsp got=%h %b %b want=%h %b %b", rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        @(negedge clk_i);
    endtask
    task automatic test_slverr_hold();
        int ok = 0;
        rsp_ready_i = 1'b0;
        sb.push_back('{rdata: 32'hBAD0BAD0, err: 1'b1, to: 1'b0});
        issue(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0);
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hBAD0BAD0;
        @(negedge clk_i);
        @(negedge clk_i);
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h0099;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} === {1'b1, e} &&
                cmd_ready_o === 1'b0 && psel_o === 1'b0) ok++;
            @(negedge clk_i);
        end
        total++;
        if (ok != 5) begin bad++; $display("FAIL err_hold stable_cycles got=%0d want=5", ok); end
        total++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {1'b1, e})
            begin bad++; $display("FAIL err_rsp got=%b %h %b %b want=1 %h %b %b", rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({rsp_valid_o, cmd_ready_o, psel_o} !== 3'b010)
            begin bad++; $display("FAIL err_release got=%b want=010", {rsp_valid_o, cmd_ready_o, psel_o}); end
    endtask
    task automatic test_timeout();
        int pen = 0;
        pready_i = 1'b0; prdata_i = 32'h55555555;
        sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        issue(1'b0, 16'h0030, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if ({psel_o, penable_o, rsp_valid_o} === 3'b110) pen++;
        end
        total++;
        if (pen != 8) begin bad++; $display("FAIL to_access_cycles got=%0d want=8", pen); end
        @(negedge clk_i);
        total++;
        if ({psel_o, penable_o, rsp_valid_o} !== 3'b001)
            begin bad++; $display("FAIL to_drop got=%b want=001", {psel_o, penable_o, rsp_valid_o}); end
        e = sb.pop_front();
        total++;
        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e)
            begin bad++; $display("FAIL to_rsp got=%h %b %b want=%h %b %b", rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        prdata_i = '0;
        @(negedge clk_i);
    endtask
    task automatic test_wait_busy();
        int idle = 0;
        busy_i = 1'b1; pready_i = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        issue(1'b1, 16'h0040, 32'hCAFEF00D, 4'h3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if ({psel_o, penable_o, rsp_valid_o} === 3'b000) idle++;
            if (i == 5) busy_i = 1'b0;
            @(negedge clk_i);
        end
        total++;
        if (idle != 6) begin bad++; $display("FAIL busy_hold cycles got=%0d want=6", idle); end
        total++;
        if ({psel_o, penable_o, paddr_o, pwdata_o, pstrb_o} !== {2'b10, 16'h0040, 32'hCAFEF00D, 4'h3})
            begin bad++; $display("FAIL busy_setup got=%b %h %h %h want=10 0040 cafef00d 3", {psel_o, penable_o}, paddr_o, pwdata_o, pstrb_o); end
        @(negedge clk_i);
        total++;
        if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL busy_access got=%b want=11", {psel_o, penable_o}); end
        @(negedge clk_i);
        pready_i = 1'b0;
        e = sb.pop_front();
        total++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {1'b1, e})
            begin bad++; $display("FAIL busy_rsp got=%b %h %b %b want=1 %h %b %b", rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        @(negedge clk_i);
    endtask
    task automatic test_busy_timeout();
        int idle = 0;
        busy_i = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        issue(1'b1, 16'h0044, 32'h11111111, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if ({psel_o, penable_o, rsp_valid_o} === 3'b000) idle++;
            @(negedge clk_i);
        end
        total++;
        if (idle != 8) begin bad++; $display("FAIL busy_to_wait cycles got=%0d want=8", idle); end
        e = sb.pop_front();
        total++;
        if ({rsp_valid_o, psel_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {2'b10, e})
            begin bad++; $display("FAIL busy_to_rsp got=%b %b %h %b %b want=1 0 %h %b %b", rsp_valid_o, psel_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        busy_i = 1'b0;
        @(negedge clk_i);
    endtask
    task automatic test_reset_mid();
        int quiet = 0;
        int w = 0;
        pready_i = 1'b0;
        issue(1'b0, 16'h0050, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        total++;
        if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL rst_mid_access got=%b want=11", {psel_o, penable_o}); end
        rst_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({psel_o, penable_o, rsp_valid_o} !== 3'b000)
            begin bad++; $display("FAIL rst_mid_drop got=%b want=000", {psel_o, penable_o, rsp_valid_o}); end
        rst_i = 1'b0; pready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b0 && cmd_ready_o === 1'b1 && psel_o === 1'b0) quiet++;
        end
        total++;
        if (quiet != 4) begin bad++; $display("FAIL rst_mid_quiet cycles got=%0d want=4", quiet); end
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        issue(1'b1, 16'h0060, 32'h0BADF00D, 4'h5, 1'b0);
        while (rsp_valid_o !== 1'b1 && w < 20) begin @(negedge clk_i); w++; end
        total++;
        if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL rst_next_rsp timeout got=%b want=1", rsp_valid_o); end
        e = sb.pop_front();
        total++;
        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e)
            begin bad++; $display("FAIL rst_next_data got=%h %b %b want=%h %b %b", rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
        pready_i = 1'b0;
        @(negedge clk_i);
    endtask
    task automatic test_back_to_back();
        int c = 0;
        pready_i = 1'b1; rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            while (cmd_ready_o !== 1'b1 && c < 10) begin
                if (rsp_valid_o === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin bad++; $display("FAIL b2b_unexpected_rsp got=%h want=none", rsp_rdata_o); end
                    else begin
                        e = sb.pop_front();
                        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e)
                            begin bad++; $display("FAIL b2b_rsp got=%h %b %b want=%h %b %b", rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to); end
                    end
                end
                @(negedge clk_i);
                c++;
            end
            if (k > 0) begin
                total++;
                if (c != 4) begin bad++; $display("FAIL b2b_period cmd%0d got=%0d want=4", k, c); end
            end
            if (k == 3) break;
            cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0100 + 16'(k);
            cmd_wait_busy_i = 1'b0; prdata_i = 32'hB0B00000 + 32'(k);
            sb.push_back('{rdata: 32'hB0B00000 + 32'(k), err: 1'b0, to: 1'b0});
            @(posedge clk_i);
            @(negedge clk_i);
            c = 1;
        end
        cmd_valid_i = 1'b0; pready_i = 1'b0;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain left=%0d want=0", sb.size()); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr_hold();
        test_timeout();
        test_wait_busy();
        test_busy_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
APB initiator that drives the matmul accelerator's APB slave port from a simple command/response stream. It is used by the on-chip sequencer and the testbench stimulus layer. Each accepted command becomes one APB transfer (SETUP then ACCESS), with optional pre-issue polling of the accelerator busy flag and a pready timeout. Read data and error status return on a valid/ready response channel.

Parameters:
BUS_WIDTH, 32, APB data width (pwdata/prdata).
ADDR_WIDTH, 16, APB address width.
MAX_DIM, 4, pstrb width (one strobe bit per byte lane, codebase convention).
TIMEOUT_CYCLES, 255, max cycles waiting in ACCESS or WAIT_BUSY; 0 disables timeout.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  target address
cmd_wdata_i  in  BUS_WIDTH  write data
cmd_strb_i  in  MAX_DIM  write strobes
cmd_wait_busy_i  in  1  1=hold issue until busy_i low
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes/timeouts)
rsp_err_o  out  1  pslverr or timeout
rsp_timeout_o  out  1  timeout occurred
psel_o, penable_o, pwrite_o  out  1 each  APB control
paddr_o  out  ADDR_WIDTH  APB address
pwdata_o  out  BUS_WIDTH  APB write data
pstrb_o  out  MAX_DIM  APB strobes
pready_i, pslverr_i  in  1 each  APB slave status
prdata_i  in  BUS_WIDTH  APB read data
busy_i  in  1  accelerator busy flag

Behaviour:
- Reset (rst_i high at edge): state IDLE; all outputs 0 except cmd_ready_o=1 in the cycle following reset; command register, counter cleared. Reset mid-transfer: psel_o/penable_o low at next edge, in-flight transfer and pending response discarded, no rsp_valid_o.
- States: IDLE, WAIT_BUSY, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o=1 (combinational from state only). On handshake, register write/addr/wdata/strb/wait_busy; next state WAIT_BUSY if cmd_wait_busy_i&&busy_i, else SETUP.
- WAIT_BUSY: psel_o=0. busy_i sampled low -> SETUP. Counter increments each cycle; reaching TIMEOUT_CYCLES (nonzero) -> RESP with err=1, timeout=1, rdata=0, no APB transfer issued.
- SETUP (1 cycle): psel_o=1, penable_o=0 -> ACCESS.
- ACCESS: psel_o=1, penable_o=1; counter restarts at 0 on entry. pready_i high at edge -> capture prdata_i (reads only, writes give 0) and pslverr_i into response regs, -> RESP. Counter reaching TIMEOUT_CYCLES without pready -> RESP, err=1, timeout=1, rdata=0; psel_o/penable_o drop same edge.
- pwrite_o/paddr_o/pwdata_o/pstrb_o driven from command register, stable through SETUP+ACCESS. pstrb_o=0 on reads. pwdata_o=0 on reads. Outside transfers all APB outputs 0.
- RESP: rsp_valid_o=1, response fields held stable until rsp_ready_i; on handshake -> IDLE. No new command accepted while RESP.
- Latency, zero-wait slave: accept at edge N; psel_o=1 cycle N+1; penable_o=1 cycle N+2; pready at N+2 -> rsp_valid_o cycle N+3. Each wait state adds one cycle. Min 4 cycles per command with rsp_ready_i tied high.
- pready_i ignored outside ACCESS. pslverr_i sampled only with pready_i.
- Counter width: clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

Test Plan:
- Write addr 0x0004, data 0xDEADBEEF, strb 4'hF, pready tied 1 -> psel cycle N+1, penable N+2, pwrite=1, rsp_valid N+3, err=0, rdata=0.
- Read addr 0x0010, slave returns 0x12345678 after 3 wait states -> penable high 4 cycles, rsp_rdata=0x12345678, pstrb_o=0, rsp_valid at N+6.
- Read with pslverr_i=1 at pready -> rsp_err=1, rsp_timeout=0; rsp_ready held low 5 cycles -> response stable, cmd_ready_o=0 throughout.
- TIMEOUT_CYCLES=8, pready never asserts -> psel/penable drop after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rdata=0.
- cmd_wait_busy_i=1, busy_i high 6 cycles then low -> psel_o stays 0 for 6 cycles, SETUP starts cycle after busy_i sampled low, normal completion.
- rst_i asserted during ACCESS -> psel/penable 0 next edge, no rsp_valid; next command after reset completes normally.
